// File: rtl/lsu.sv
// Load/store unit: one blocking EXU transaction at a time, word-addressed
// memory port with byte strobes, extended load data back to WBU.
module lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic [2:0]       in_mem_op,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_rdata,
  output logic             out_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_we,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic             mem_resp_valid,
  output logic             mem_resp_ready,
  input  logic [WIDTH-1:0] mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] op_q;
  logic [1:0] off_q;

  logic             acc_err;
  logic [3:0]       acc_strb;
  logic [WIDTH-1:0] acc_lane;

  always_comb begin
    acc_err  = 1'b0;
    acc_strb = 4'b0000;
    acc_lane = in_wdata;
    unique case (1'b1)
      in_mem_op[1:0] == 2'b00: begin
        acc_lane = {4{in_wdata[7:0]}};
        acc_strb = 4'b0001 << in_addr[1:0];
      end
      in_mem_op[1:0] == 2'b01: begin
        acc_err  = in_addr[0];
        acc_lane = {2{in_wdata[15:0]}};
        acc_strb = 4'b0011 << in_addr[1:0];
      end
      in_mem_op[1:0] == 2'b10: begin
        acc_err  = |in_addr[1:0];
        acc_strb = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
    if (!in_we) acc_strb = 4'b0000;
  end

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] ld_data;

  always_comb begin
    shifted = mem_resp_rdata >> {off_q, 3'b000};
    ld_data = shifted;
    unique case (1'b1)
      op_q[1:0] == 2'b00:
        ld_data = op_q[2] ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                          : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      op_q[1:0] == 2'b01:
        ld_data = op_q[2] ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                          : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // Handshake outputs are registers updated on each state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      we_q           <= 1'b0;
      op_q           <= 3'b000;
      off_q          <= 2'b00;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      out_rdata      <= '0;
      out_err        <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      mem_req_wstrb  <= 4'b0000;
      mem_resp_ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            we_q     <= in_we;
            op_q     <= in_mem_op;
            off_q    <= in_addr[1:0];
            in_ready <= 1'b0;
            if (acc_err) begin
              out_err   <= 1'b1;
              out_rdata <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_we    <= in_we;
              mem_req_addr  <= {in_addr[WIDTH-1:2], 2'b00};
              mem_req_wdata <= acc_lane;
              mem_req_wstrb <= acc_strb;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            mem_resp_ready <= 1'b0;
            out_rdata      <= we_q ? '0 : ld_data;
            out_err        <= 1'b0;
            out_valid      <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed loads/stores against a scripted
// memory responder, with a separate monitor checking WBU results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_we = 1'b0;
  logic [2:0]  in_mem_op = 3'b000;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;

  lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we),
    .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chkw;
    logic [31:0] word;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  req_t req_q[$];
  res_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int nres = 0;
  int nexp = 0;
  int req_dly = 0;
  int resp_dly = 0;
  int bp = 0;
  bit spur = 1'b0;

  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  function automatic bit at_reset_vals();
    return in_ready && !out_valid && out_rdata == 0 && !out_err &&
           !mem_req_valid && !mem_req_we && mem_req_addr == 0 &&
           mem_req_wdata == 0 && mem_req_wstrb == 0 && !mem_resp_ready;
  endfunction

  // Memory responder
  initial begin
    req_t r;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        if (req_q.size() == 0) begin
          chk(1'b0, $sformatf("unexpected_mem_req got addr=%h want none",
                              mem_req_addr));
          mem_req_ready = 1'b1;
          @(negedge clk);
          mem_req_ready = 1'b0;
          mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0;
        end else begin
          r = req_q.pop_front();
          for (int i = 0; i <= req_dly; i++) begin
            if (i > 0) @(negedge clk);
            chk(mem_req_valid && mem_req_we == r.we &&
                mem_req_addr == r.addr && mem_req_wstrb == r.strb &&
                (!r.chkw || mem_req_wdata == r.wdata) && !in_ready,
                $sformatf({"req_fields c%0d got v=%b we=%b a=%h d=%h s=%b ",
                           "ir=%b want we=%b a=%h d=%h s=%b"},
                          i, mem_req_valid, mem_req_we, mem_req_addr,
                          mem_req_wdata, mem_req_wstrb, in_ready,
                          r.we, r.addr, r.wdata, r.strb));
          end
          mem_req_ready = 1'b1;
          @(negedge clk);
          mem_req_ready = 1'b0;
          for (int i = 0; i < resp_dly; i++) @(negedge clk);
          mem_resp_rdata = r.word;
          mem_resp_valid = 1'b1;
          @(negedge clk);
          mem_resp_valid = 1'b0;
        end
      end else begin
        mem_resp_valid = spur;
      end
    end
  end

  // Result monitor / scoreboard
  initial begin
    int hold;
    res_t e;
    hold = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (hold < bp) begin
          out_ready = 1'b0;
          hold++;
          chk(!in_ready, $sformatf("busy_in_ready got %b want 0", in_ready));
        end else begin
          out_ready = 1'b1;
          hold = 0;
          nres++;
          if (exp_q.size() == 0) begin
            chk(1'b0, $sformatf("unexpected_result got rd=%h err=%b",
                                out_rdata, out_err));
          end else begin
            e = exp_q.pop_front();
            chk(out_rdata == e.rdata && out_err == e.err,
                $sformatf("result got rd=%h err=%b want rd=%h err=%b",
                          out_rdata, out_err, e.rdata, e.err));
          end
        end
      end else begin
        out_ready = 1'b0;
        hold = 0;
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] word, input logic [31:0] ewd,
                       input logic [3:0] estrb, input logic [31:0] erd,
                       input logic eerr, input bit want_out);
    int n;
    req_t r;
    res_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk(1'b0, "issue_timeout got in_ready=0 want 1");
    if (!eerr) begin
      r.we = we;
      r.addr = {addr[31:2], 2'b00};
      r.wdata = ewd;
      r.strb = estrb;
      r.chkw = we;
      r.word = word;
      req_q.push_back(r);
    end
    if (want_out) begin
      e.rdata = erd;
      e.err = eerr;
      exp_q.push_back(e);
      nexp++;
    end
    in_valid = 1'b1;
    in_we = we;
    in_mem_op = op;
    in_addr = addr;
    in_wdata = wd;
    @(negedge clk);
    in_valid = 1'b0;
    in_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready && !out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(1'b0, $sformatf("done_timeout got pending=%0d want 0",
                                      exp_q.size()));
  endtask

  task automatic err_case(input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input string nm);
    bit seen;
    issue(we, op, addr, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (out_valid) seen = 1'b1;
      if (!seen) @(negedge clk);
    end
    chk(seen, $sformatf("%s_latency got out_valid=%b want 1", nm, out_valid));
    wait_done();
  endtask

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    chk(at_reset_vals(), "reset_values got nonreset want reset state");
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 3'b000, 32'h8000_0003, 0, 32'h80FF_1234, 0, 4'h0,
          32'hFFFF_FF80, 0, 1);
    wait_done();
    issue(0, 3'b100, 32'h8000_0003, 0, 32'h80FF_1234, 0, 4'h0,
          32'h0000_0080, 0, 1);
    wait_done();
    issue(0, 3'b001, 32'h8000_0002, 0, 32'h8001_7FFF, 0, 4'h0,
          32'hFFFF_8001, 0, 1);
    wait_done();
    issue(0, 3'b101, 32'h8000_0002, 0, 32'h8001_7FFF, 0, 4'h0,
          32'h0000_8001, 0, 1);
    wait_done();
    issue(0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 4'h0,
          32'hDEAD_BEEF, 0, 1);
    wait_done();
    issue(0, 3'b000, 32'h8000_0001, 0, 32'h1122_3344, 0, 4'h0,
          32'h0000_0033, 0, 1);
    wait_done();
    issue(0, 3'b001, 32'h8000_0000, 0, 32'h0000_F00F, 0, 4'h0,
          32'hFFFF_F00F, 0, 1);
    wait_done();
    issue(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0, 32'hABAB_ABAB,
          4'b0010, 32'h0, 0, 1);
    wait_done();
    issue(1, 3'b001, 32'h8000_0002, 32'hFFFF_1234, 0, 32'h1234_1234,
          4'b1100, 32'h0, 0, 1);
    wait_done();
    issue(1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 32'hCAFE_F00D,
          4'b1111, 32'h0, 0, 1);
    wait_done();

    err_case(0, 3'b010, 32'h8000_0002, "lw_mis");
    err_case(0, 3'b001, 32'h8000_0001, "lh_mis");
    err_case(0, 3'b011, 32'h8000_0000, "size11");
    err_case(1, 3'b010, 32'h8000_0001, "sw_mis");

    req_dly = 3;
    resp_dly = 4;
    bp = 2;
    issue(0, 3'b010, 32'h8000_000C, 0, 32'h0BAD_F00D, 0, 4'h0,
          32'h0BAD_F00D, 0, 1);
    wait_done();
    req_dly = 0;
    resp_dly = 0;
    bp = 0;

    spur = 1'b1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready || mem_resp_ready) ok = 1'b0;
    end
    spur = 1'b0;
    @(negedge clk);
    chk(ok && !out_valid, $sformatf("spurious_resp got out_valid=%b want 0",
                                    out_valid));

    resp_dly = 6;
    issue(0, 3'b010, 32'h8000_0010, 0, 32'h1234_5678, 0, 4'h0, 0, 0, 0);
    n = 0;
    while (!mem_resp_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(mem_resp_ready, "reach_wait got mem_resp_ready=0 want 1");
    rst_n = 1'b0;
    #1;
    chk(at_reset_vals(), $sformatf(
        "midreset_values got ir=%b ov=%b rqv=%b rsr=%b want 1 0 0 0",
        in_ready, out_valid, mem_req_valid, mem_resp_ready));
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid || !in_ready || mem_resp_ready || mem_req_valid)
        ok = 1'b0;
    end
    chk(ok, "stale_resp got activity want idle");
    resp_dly = 0;

    issue(0, 3'b010, 32'h8000_0014, 0, 32'hFACE_B00C, 0, 4'h0,
          32'hFACE_B00C, 0, 1);
    wait_done();

    repeat (3) @(negedge clk);
    chk(nres == nexp && exp_q.size() == 0 && req_q.size() == 0,
        $sformatf("result_count got %0d pend=%0d/%0d want %0d pend=0/0",
                  nres, exp_q.size(), req_q.size(), nexp));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
